// File: rtl/bsr_pkg.sv
// Shared constants for the bidirectional shift-register family (PISO/SIPO/SISO).
// Mode encoding matches the serial direction: 1 shifts toward the MSB, 0 toward the LSB.
package bsr_pkg;

    localparam logic MODE_LEFT     = 1'b1;
    localparam logic MODE_RIGHT    = 1'b0;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/bsr_piso.sv
// Purpose: bidirectional parallel-in/serial-out shifter, MSB- or LSB-first per mode.
// Latency: first bit on sout in the cycle right after the load edge; one bit per clock after that.
// Backpressure: none; the consumer samples sout every rising edge, and a load aborts the word in flight.
module bsr_piso
    import bsr_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] pin,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // Load ignores mode entirely, so an unknown mode on a load edge cannot reach q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= pin;
        end else if (mode == MODE_LEFT) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end else begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign sout = (mode == MODE_LEFT) ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_bsr_piso.sv
// Bench for bsr_piso: directed sequences plus random traffic against an arithmetic model of q.
// The driver pushes the expected sout for each cycle; a negedge monitor pops and compares.
module tb_bsr_piso;

    localparam int W = 4;

    typedef struct {
        logic exp;
        bit   care;
        int   tag;
    } sb_entry_t;

    logic         clk;
    logic         rst;
    logic         load;
    logic         mode;
    logic [W-1:0] pin;
    logic         sout;

    sb_entry_t sb_q[$];
    int        errors;
    int        checks;

    // Reference state: plain integer value of the register.
    int model_q;
    bit model_valid;

    bsr_piso #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .mode (mode),
        .pin  (pin),
        .sout (sout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs for one cycle, record what sout must show mid-cycle, then
    // advance the model to the value the register takes at the closing edge.
    task automatic drive(input bit r, input bit l, input logic m, input logic [W-1:0] p, input int tag);
        sb_entry_t e;
        @(posedge clk);
        #1;
        rst  = r;
        load = l;
        mode = m;
        pin  = p;
        e.tag  = tag;
        e.care = model_valid && !$isunknown(m);
        if (m === 1'b1)
            e.exp = ((model_q / (2 ** (W - 1))) % 2) != 0;
        else
            e.exp = (model_q % 2) != 0;
        sb_q.push_back(e);
        if (r) begin
            model_q     = 0;
            model_valid = 1'b1;
        end else if (l) begin
            model_q     = int'(p);
            model_valid = 1'b1;
        end else if (m === 1'b1) begin
            model_q = (model_q * 2) % (2 ** W);
        end else begin
            model_q = model_q / 2;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                if (e.care) begin
                    checks++;
                    if (sout !== e.exp) begin
                        errors++;
                        $display("FAIL sout tag=%0d t=%0t got=%b want=%b", e.tag, $time, sout, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        errors      = 0;
        checks      = 0;
        model_q     = 0;
        model_valid = 1'b0;
        rst  = 1'b1;
        load = 1'b0;
        mode = 1'b0;
        pin  = '0;

        // 1: reset held two edges, load asserted alongside must be ignored
        drive(1, 1, 1'b1, 4'b1111, 1);
        drive(1, 1, 1'b1, 4'b1111, 1);
        drive(0, 0, 1'b1, 4'b0000, 1);
        drive(0, 0, 1'b0, 4'b0000, 1);

        // 2: load 1011, shift left -> 1,0,1,1,0,0
        drive(0, 1, 1'b0, 4'b1011, 2);
        for (int i = 0; i < 6; i++) drive(0, 0, 1'b1, 4'b0000, 2);

        // 3: load 0111, shift right -> 1,1,1,0,0
        drive(0, 1, 1'b1, 4'b0111, 3);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'b0, 4'b0000, 3);

        // 4: load 1011, two left shifts, reload 0110, drain left
        drive(0, 1, 1'b1, 4'b1011, 4);
        drive(0, 0, 1'b1, 4'b0000, 4);
        drive(0, 0, 1'b1, 4'b0000, 4);
        drive(0, 1, 1'b1, 4'b0110, 4);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'b1, 4'b0000, 4);

        // 5: load 1001, one right shift, then switch to left mid-stream
        drive(0, 1, 1'b0, 4'b1001, 5);
        drive(0, 0, 1'b0, 4'b0000, 5);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'b1, 4'b0000, 5);

        // 6: reset mid-shift, then shifting resumes from zero
        drive(0, 1, 1'b1, 4'b1111, 6);
        drive(0, 0, 1'b1, 4'b0000, 6);
        drive(1, 0, 1'b1, 4'b0000, 6);
        for (int i = 0; i < 4; i++) drive(0, 0, 1'b1, 4'b0000, 6);

        // 7: unknown mode on a load edge must leave the loaded word intact
        drive(0, 1, 1'bx, 4'b1101, 7);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'b1, 4'b0000, 7);
        drive(0, 1, 1'bx, 4'b1010, 7);
        for (int i = 0; i < 5; i++) drive(0, 0, 1'b0, 4'b0000, 7);

        // 8: random traffic, including mode flips and reloads mid-word
        for (int i = 0; i < 400; i++) begin
            bit           r;
            bit           l;
            logic         m;
            logic [W-1:0] p;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 4) == 0);
            m = 1'($urandom_range(0, 1));
            p = W'($urandom);
            drive(r, l, m, p, 8);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
